pwr_rail_sequencer: RTL
=======================

// Module: pwr_rail_sequencer
// PURPOSE
//  Timed power-rail sequencer driven by the 1 ms tick from the clock-enable generator.
//  - Enables NUM_RAILS rails in ascending order: each rail must report power-good, then an inter-rail delay runs before the next rail is enabled.
//  - Disables rails in descending order with a per-rail off delay.
//  - Flags PG timeout and PG loss as a fault and drops all rails at once.
// PARAMETERS
//  NUM_RAILS  4      number of rails sequenced (2..8)
//  DLY_W      8      width of ms delay counter and delay params
//  ON_DLY     8'd10  ms from PG of rail i to enable of rail i+1 (>=1)
//  PG_TMO     8'd50  ms allowed from enable of rail i to its PG (>=1)
//  OFF_DLY    8'd5   ms between successive rail disables (>=1)
// PORTS
//  clk         in   1          system clock (2 MHz)
//  nrst        in   1          async active-low reset
//  tick_1ms    in   1          1-clk pulse every 1 ms (clock-enable generator 1 kHz output)
//  pwr_on_req  in   1          level; 1 = sequence up / stay on, 0 = sequence down
//  pg_in       in   NUM_RAILS  async power-good per rail, active-high
//  rail_en     out  NUM_RAILS  rail enables, registered
//  seq_done    out  1          1 while all rails on and good (state ON)
//  fault       out  1          sticky fault flag
//  fault_rail  out  3          index of failing rail (lowest failing index if several)
//  seq_state   out  3          current FSM state encoding, for debug/LED
// BEHAVIOUR
//  Reset values: rail_en=0, seq_done=0, fault=0, fault_rail=0, seq_state=IDLE, idx=0, ms_cnt=0.
//  pg_in passes a 2-FF synchronizer (pg_s); PG-to-FSM latency is 2 clk.
//  ms_cnt clears on every state entry and increments only on tick_1ms. A delay of D completes on the D-th tick after entry, so actual time is (D-1, D] ms.
//  States:
//   IDLE     - rail_en=0. pwr_on_req=1 -> idx=0, EN_RAIL.
//   EN_RAIL  - one clk: set rail_en[idx] -> WAIT_PG.
//   WAIT_PG  - pg_s[idx]=1 -> ON if idx==NUM_RAILS-1, else ON_WAIT.
//            - tick with ms_cnt==PG_TMO-1 and pg_s[idx]=0 -> FAULT, fault_rail=idx.
//   ON_WAIT  - tick with ms_cnt==ON_DLY-1 -> idx++, EN_RAIL.
//   ON       - seq_done=1 (registered; asserts 1 clk after entry).
//            - pwr_on_req=0 -> idx=NUM_RAILS-1, OFF_STEP.
//   OFF_STEP - one clk: clear rail_en[idx] -> OFF_WAIT.
//   OFF_WAIT - tick with ms_cnt==OFF_DLY-1 -> if idx==0 then IDLE, else idx--, OFF_STEP.
//   FAULT    - rail_en cleared to 0 on entry clk; fault=1.
//            - Stays until pwr_on_req=0 -> IDLE; fault clears on IDLE entry.
//  PG loss: in WAIT_PG, ON_WAIT or ON, any rail j with rail_en[j]=1 (excluding idx in WAIT_PG) and pg_s[j]=0 -> FAULT, fault_rail=lowest such j.
//   PG loss has priority over timeout and over pwr_on_req changes in the same clk.
//  pwr_on_req=0 during EN_RAIL/WAIT_PG/ON_WAIT -> OFF_STEP from the highest enabled index; disabled rails are skipped, no delay spent on them.
//  pwr_on_req=1 during OFF_STEP/OFF_WAIT: the down-sequence completes to IDLE, then restarts from IDLE.
//  During down-sequence PG is ignored (no fault).
//  tick_1ms coincident with a state entry is not counted (ms_cnt clears).
//  ms_cnt saturates at all-ones; no wrap.
//  nrst low mid-sequence drops all enables asynchronously.
// STRUCTURE
//  pwr_seq_pkg: state enum (IDLE=0, EN_RAIL, WAIT_PG, ON_WAIT, ON, OFF_STEP, OFF_WAIT, FAULT=7) and state width constant.
//  Sub-module pg_sync (parameter WIDTH): 2-FF vector synchronizer, async reset to 0.
//  Top level: FSM, idx register, ms_cnt, output registers.
// TESTING (NUM_RAILS=3, ON_DLY=2, PG_TMO=5, OFF_DLY=1, tick every 20 clk)
//  1. Power-up: req=1, pg follows en after 3 clk
//     -> rail_en 001, 011, 111 with ~2 ms between enables; seq_done=1; fault=0.
//  2. Power-down: from ON, req=0 -> rail_en 011, 001, 000 spaced 1 ms; IDLE; seq_done=0 1 clk after leaving ON.
//  3. Timeout: pg_in[1] held 0 -> 5th tick after en[1] sets gives FAULT, fault_rail=1, rail_en=000; req=0 -> IDLE, fault=0.
//  4. PG loss in ON: drop pg_in[0] -> within 3 clk FAULT, fault_rail=0, rail_en=000.
//  5. Abort mid-up: req=0 while WAIT_PG on rail 1 -> rail 1 then rail 0 off in descending order; IDLE; no fault.
//  6. Async reset: nrst low in ON_WAIT -> rail_en=000 immediately; after release, state IDLE and req=1 restarts from rail 0.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Power-rail sequencer shared types.
// State encoding is exported on seq_state.
package pwr_seq_pkg;

  localparam int STATE_W = 3;
  localparam int IDX_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_EN_RAIL  = 3'd1,
    ST_WAIT_PG  = 3'd2,
    ST_ON_WAIT  = 3'd3,
    ST_ON       = 3'd4,
    ST_OFF_STEP = 3'd5,
    ST_OFF_WAIT = 3'd6,
    ST_FAULT    = 3'd7
  } seq_state_e;

endpackage

// File: rtl/pwr_rail_sequencer_pg_sync.sv
// Two-flop synchronizer for the async
// power-good inputs.
module pg_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // metastability stage then stable stage
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwr_rail_sequencer.sv
// Timed power-rail sequencer: ascending
// power-up, descending power-down, PG faults.
module pwr_rail_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int               NUM_RAILS = 4,
  parameter int               DLY_W     = 8,
  parameter logic [DLY_W-1:0] ON_DLY    = 8'd10,
  parameter logic [DLY_W-1:0] PG_TMO    = 8'd50,
  parameter logic [DLY_W-1:0] OFF_DLY   = 8'd5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 tick_1ms,
  input  logic                 pwr_on_req,
  input  logic [NUM_RAILS-1:0] pg_in,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 seq_done,
  output logic                 fault,
  output logic [2:0]           fault_rail,
  output logic [2:0]           seq_state
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_RAILS - 1);
  localparam logic [DLY_W-1:0] ON_LIM  =
    ON_DLY - 1'b1;
  localparam logic [DLY_W-1:0] PG_LIM  =
    PG_TMO - 1'b1;
  localparam logic [DLY_W-1:0] OFF_LIM =
    OFF_DLY - 1'b1;

  seq_state_e           state_q, state_d;
  seq_state_e           abort_st;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DLY_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 seq_done_q, seq_done_d;
  logic                 fault_q, fault_d;
  logic [IDX_W-1:0]     fault_rail_q;
  logic [IDX_W-1:0]     fault_rail_d;

  logic [NUM_RAILS-1:0] pg_s;
  logic [NUM_RAILS-1:0] idx_oh;
  logic [NUM_RAILS-1:0] loss;
  logic [IDX_W-1:0]     top_en;
  logic [IDX_W-1:0]     low_loss;
  logic                 pg_cur;

  pg_sync #(
    .WIDTH (NUM_RAILS)
  ) u_pg_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (pg_in),
    .q    (pg_s)
  );

  // rail selection, PG-loss detect, abort target
  always_comb begin
    idx_oh   = '0;
    top_en   = '0;
    low_loss = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      idx_oh[i] = (idx_q == IDX_W'(i));
      if (rail_en_q[i]) top_en = IDX_W'(i);
    end
    loss = rail_en_q & ~pg_s;
    if (state_q == ST_WAIT_PG)
      loss = loss & ~idx_oh;
    if (!(state_q inside
          {ST_WAIT_PG, ST_ON_WAIT, ST_ON}))
      loss = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--)
      if (loss[i]) low_loss = IDX_W'(i);
    pg_cur   = |(pg_s & idx_oh);
    abort_st = (|rail_en_q) ? ST_OFF_STEP
                            : ST_IDLE;
  end

  // next state, rail enables and fault index
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    unique case (state_q)
      ST_IDLE: begin
        rail_en_d = '0;
        if (pwr_on_req) begin
          idx_d   = '0;
          state_d = ST_EN_RAIL;
        end
      end
      ST_EN_RAIL: begin
        if (!pwr_on_req) begin
          idx_d   = top_en;
          state_d = abort_st;
        end else begin
          rail_en_d = rail_en_q | idx_oh;
          state_d   = ST_WAIT_PG;
        end
      end
      ST_WAIT_PG: begin
        if (|loss) begin
          fault_rail_d = low_loss;
          state_d      = ST_FAULT;
        end else if (!pwr_on_req) begin
          idx_d   = top_en;
          state_d = abort_st;
        end else if (pg_cur) begin
          state_d = (idx_q == LAST) ? ST_ON
                                    : ST_ON_WAIT;
        end else if (tick_1ms &&
                     ms_cnt_q == PG_LIM) begin
          fault_rail_d = idx_q;
          state_d      = ST_FAULT;
        end
      end
      ST_ON_WAIT: begin
        if (|loss) begin
          fault_rail_d = low_loss;
          state_d      = ST_FAULT;
        end else if (!pwr_on_req) begin
          idx_d   = top_en;
          state_d = abort_st;
        end else if (tick_1ms &&
                     ms_cnt_q == ON_LIM) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_EN_RAIL;
        end
      end
      ST_ON: begin
        if (|loss) begin
          fault_rail_d = low_loss;
          state_d      = ST_FAULT;
        end else if (!pwr_on_req) begin
          idx_d   = LAST;
          state_d = ST_OFF_STEP;
        end
      end
      ST_OFF_STEP: begin
        rail_en_d = rail_en_q & ~idx_oh;
        state_d   = ST_OFF_WAIT;
      end
      ST_OFF_WAIT: begin
        if (tick_1ms && ms_cnt_q == OFF_LIM) begin
          if (idx_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_OFF_STEP;
          end
        end
      end
      ST_FAULT: begin
        if (!pwr_on_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FAULT) rail_en_d = '0;
  end

  // delay counter, status flags
  always_comb begin
    fault_d    = fault_q;
    seq_done_d = (state_q == ST_ON);
    ms_cnt_d   = ms_cnt_q;
    if (state_d == ST_FAULT)
      fault_d = 1'b1;
    else if (state_d == ST_IDLE)
      fault_d = 1'b0;
    if (state_d != state_q)
      ms_cnt_d = '0;
    else if (tick_1ms && ms_cnt_q != '1)
      ms_cnt_d = ms_cnt_q + 1'b1;
  end

  // state and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ms_cnt_q     <= '0;
      rail_en_q    <= '0;
      seq_done_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ms_cnt_q     <= ms_cnt_d;
      rail_en_q    <= rail_en_d;
      seq_done_q   <= seq_done_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign seq_done   = seq_done_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign seq_state  = state_q;

endmodule
